// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_pkg                                                    |
// | Brief   : Shared state encoding and constants for the SPI target.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int          RW_BIT      = 7;
  localparam int          ADDR_W      = 7;
  localparam logic [6:0]  WHOAMI_ADDR = 7'h0F;
  localparam logic [7:0]  WHOAMI_VAL  = 8'h33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_sync_edge                                              |
// | Brief   : Multi-flop input synchronizer with rise/fall pulse outputs.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // No reset: a reset must not fabricate a CS edge while the pin is low.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    r_prev <= r_sync[SYNC_STAGES-1];
  end

  assign dout = r_sync[SYNC_STAGES-1];
  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_target                                                 |
// | Brief   : Mode-3 SPI responder with an 8-bit register bank and a     |
// |           fabric host port. SPI_TARGET_WHOAMI_EN makes 0x0F a        |
// |           read-only ID register returning 0x33.                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_target
  import spi_pkg::*;
#(
  parameter int NREGS       = 128,
  parameter int AUTO_INC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CS,
  input  logic              SPC,
  input  logic              SDI,
  output logic              SDO,
  output logic              SDO_oe,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int                c_IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W-1:0] c_INC   = (AUTO_INC != 0) ? 7'd1 : 7'd0;

  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_spc, w_spc_rise, w_spc_fall, w_unused_spc;
  logic w_rise, w_fall, w_sdi;
  logic [SYNC_STAGES-1:0] r_sdi_sync;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift, r_tx, w_rd_byte;
  logic              r_rw, r_sdo, r_commit, w_sdo_oe;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_spi_we, w_host_we;
  logic [7:0]        r_regs [NREGS];

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk (clk), .din (CS), .dout (w_cs), .rise (w_cs_rise), .fall (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_spc_sync (
    .clk (clk), .din (SPC), .dout (w_spc), .rise (w_spc_rise), .fall (w_spc_fall)
  );

  assign w_unused_spc = w_spc;

  always_ff @(posedge clk) begin
    r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
  end
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  // Clock edges only count while the synchronized chip select is asserted.
  assign w_rise = w_spc_rise & ~w_cs;
  assign w_fall = w_spc_fall & ~w_cs;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < 8'(NREGS));
  endfunction

  function automatic logic f_is_ro(input logic [ADDR_W-1:0] a);
`ifdef SPI_TARGET_WHOAMI_EN
    return (a == WHOAMI_ADDR);
`else
    return (a == WHOAMI_ADDR) & 1'b0;
`endif
  endfunction

  function automatic logic [7:0] f_read(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (f_in_range(a)) v = r_regs[a[c_IDX_W-1:0]];
    if (f_is_ro(a))    v = WHOAMI_VAL;
    return v;
  endfunction

  assign w_rd_byte  = f_read(r_addr);
  assign host_rdata = f_read(host_addr);

  assign w_spi_we  = r_commit & f_in_range(r_addr) & ~f_is_ro(r_addr);
  assign w_host_we = host_we & f_in_range(host_addr) & ~f_is_ro(host_addr)
                   & ~(w_spi_we & (host_addr == r_addr));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sdo_oe    = 1'b0;
    unique case (r_state)
      IDLE: if (w_cs_fall) w_state_nxt = CMD;
      CMD: begin
        if (w_cs_rise)                          w_state_nxt = IDLE;
        else if (w_rise && r_bit_cnt == 4'd7)   w_state_nxt = DATA;
      end
      DATA: begin
        w_sdo_oe = r_rw;
        if (w_cs_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_sdo       <= 1'b1;
      r_commit    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
    end else begin
      r_commit    <= 1'b0;
      r_wr_strobe <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
          end
        end
        CMD: begin
          if (!w_cs_rise && w_rise) begin
            r_shift <= {r_shift[6:0], w_sdi};
            if (r_bit_cnt == 4'd7) begin
              r_rw      <= r_shift[RW_BIT-1];
              r_addr    <= {r_shift[5:0], w_sdi};
              r_bit_cnt <= 4'd0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (!w_cs_rise && r_rw) begin
            // The byte is snapshotted at the first falling edge of each slot.
            if (w_fall) begin
              if (r_bit_cnt == 4'd0) begin
                r_sdo <= w_rd_byte[7];
                r_tx  <= {w_rd_byte[6:0], 1'b0};
              end else begin
                r_sdo <= r_tx[7];
                r_tx  <= {r_tx[6:0], 1'b0};
              end
            end
            if (w_rise) begin
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= 4'd0;
                r_addr    <= r_addr + c_INC;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end else if (!w_cs_rise && w_rise) begin
            r_shift   <= {r_shift[6:0], w_sdi};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) r_commit <= 1'b1;
          end
        end
        default: r_bit_cnt <= 4'd0;
      endcase

      // A completed byte commits even if CS rises in the same cycle.
      if (r_commit) begin
        r_addr    <= r_addr + c_INC;
        r_bit_cnt <= 4'd0;
        if (!f_is_ro(r_addr)) begin
          r_wr_strobe <= 1'b1;
          r_wr_addr   <= r_addr;
          r_wr_data   <= r_shift;
        end
      end

      if (w_cs_rise) r_sdo <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_host_we) r_regs[host_addr[c_IDX_W-1:0]] <= host_wdata;
      if (w_spi_we)  r_regs[r_addr[c_IDX_W-1:0]]    <= r_shift;
    end
  end

  assign SDO       = r_sdo;
  assign SDO_oe    = w_sdo_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_target                                              |
// | Brief   : Randomized self-checking bench for spi_target (128 and 64  |
// |           register builds side by side against a register model).    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_spi_target;

  localparam int HALF = 6;

  logic       clk, reset, cs, spc, sdi;
  logic       host_we;
  logic [6:0] host_addr;
  logic [7:0] host_wdata;
  logic       sdo, sdo_oe, wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, host_rdata;
  logic       sdo64, sdo_oe64, wr_strobe64;
  logic [6:0] wr_addr64;
  logic [7:0] wr_data64, host_rdata64;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m128 [128];
  logic [7:0] m64  [128];
  logic [7:0] tx_q[$], rx_q[$], rx64_q[$];
  logic [6:0] ea[$], sa[$], sa64[$];
  logic [7:0] ed[$], sd[$], sd64[$];

  spi_target #(.NREGS(128), .AUTO_INC(1), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .CS(cs), .SPC(spc), .SDI(sdi),
    .SDO(sdo), .SDO_oe(sdo_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  spi_target #(.NREGS(64), .AUTO_INC(1), .SYNC_STAGES(2)) u_dut64 (
    .clk(clk), .reset(reset), .CS(cs), .SPC(spc), .SDI(sdi),
    .SDO(sdo64), .SDO_oe(sdo_oe64),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata64),
    .wr_strobe(wr_strobe64), .wr_addr(wr_addr64), .wr_data(wr_data64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe)   begin sa.push_back(wr_addr);     sd.push_back(wr_data);     end
    if (wr_strobe64) begin sa64.push_back(wr_addr64); sd64.push_back(wr_data64); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_whoami(input logic [6:0] a);
`ifdef SPI_TARGET_WHOAMI_EN
    return a == 7'h0F;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit wr_ok(input int n, input logic [6:0] a);
    return (int'(a) < n) && !is_whoami(a);
  endfunction

  function automatic logic [7:0] rd_model(input int n, input logic [6:0] a);
    if (is_whoami(a))  return 8'h33;
    if (int'(a) >= n)  return 8'h00;
    return (n == 128) ? m128[a] : m64[a];
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (wr_ok(128, a)) m128[a] = d;
    if (wr_ok(64, a))  m64[a]  = d;
  endtask

  task automatic model_spi_write(input logic [6:0] a0, input int nfull);
    logic [6:0] a;
    for (int k = 0; k < nfull; k++) begin
      a = a0 + 7'(k);
      if (!is_whoami(a)) begin
        ea.push_back(a);
        ed.push_back(tx_q[k]);
      end
      model_write(a, tx_q[k]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic check_host(input logic [6:0] a);
    @(negedge clk);
    host_addr = a;
    #1;
    chk("host_rd", host_rdata, rd_model(128, a));
    chk("host_rd64", host_rdata64, rd_model(64, a));
  endtask

  task automatic check_strobes();
    chk("stb_cnt", sa.size(), ea.size());
    chk("stb64_cnt", sa64.size(), ea.size());
    for (int i = 0; i < ea.size() && i < sa.size(); i++) begin
      chk("stb_addr", sa[i], ea[i]);
      chk("stb_data", sd[i], ed[i]);
    end
    for (int i = 0; i < ea.size() && i < sa64.size(); i++) begin
      chk("stb64_addr", sa64[i], ea[i]);
      chk("stb64_data", sd64[i], ed[i]);
    end
    ea.delete(); ed.delete(); sa.delete(); sd.delete(); sa64.delete(); sd64.delete();
  endtask

  // cut < 0: complete frame; otherwise CS rises after 'cut' data bits.
  task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int cut);
    logic [7:0] b, r, r64;
    int  sent;
    bit  rd;
    rd = cmd[7];
    sent = 0;
    rx_q.delete(); rx64_q.delete();
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 0; i--) begin
      spc = 1'b0; sdi = cmd[i];
      wait_clk(HALF);
      if (i == 0) chk("oe_cmd", sdo_oe, 0);
      spc = 1'b1;
      wait_clk(HALF);
    end
    for (int k = 0; k < nbytes; k++) begin
      b = rd ? 8'h00 : tx_q[k];
      r = 8'h00; r64 = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        if (cut >= 0 && sent == cut) break;
        spc = 1'b0; sdi = b[i];
        wait_clk(HALF);
        r[i] = sdo; r64[i] = sdo64;
        if (i == 7) chk("oe_data", sdo_oe, 32'(rd));
        spc = 1'b1;
        wait_clk(HALF);
        sent++;
      end
      if (cut >= 0 && sent == cut) break;
      if (rd) begin rx_q.push_back(r); rx64_q.push_back(r64); end
    end
    wait_clk(HALF);
    cs = 1'b1; sdi = 1'b0;
    wait_clk(4 * HALF);
    chk("oe_idle", sdo_oe, 0);
    chk("sdo_idle", sdo, 1);
  endtask

  task automatic spi_read_check(input logic [6:0] a, input int n);
    spi_frame({1'b1, a}, n, -1);
    chk("rd_len", rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      chk("rd_data", rx_q[i], rd_model(128, a + 7'(i)));
      chk("rd64_data", rx64_q[i], rd_model(64, a + 7'(i)));
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input int n, input int cut);
    spi_frame({1'b0, a}, n, cut);
    model_spi_write(a, (cut < 0) ? n : cut / 8);
    check_strobes();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, op, cut, cnt;
    logic [6:0] a;
    for (int i = 0; i < 128; i++) begin m128[i] = 8'h00; m64[i] = 8'h00; end
    cs = 1'b1; spc = 1'b1; sdi = 1'b0;
    host_we = 1'b0; host_addr = 7'h00; host_wdata = 8'h00;
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    chk("rst_sdo", sdo, 1);
    chk("rst_oe", sdo_oe, 0);
    chk("rst_stb", wr_strobe, 0);
    check_host(7'h00);
    check_host(7'h20);
    check_host(7'h7F);

    // single write
    tx_q = '{8'h57};
    spi_write(7'h20, 1, -1);
    check_host(7'h20);

    // burst read
    for (int i = 0; i < 6; i++) host_write(7'h28 + 7'(i), 8'h11 * 8'(i + 1));
    spi_read_check(7'h28, 6);

    // aborted write leaves old value
    host_write(7'h21, 8'h5A);
    tx_q = '{8'hC3};
    spi_write(7'h21, 1, 4);
    check_host(7'h21);
    spi_read_check(7'h21, 1);

    // address wrap and out-of-range behaviour
    host_write(7'h7F, 8'h9C);
    host_write(7'h00, 8'h4D);
    spi_read_check(7'h7F, 2);
    tx_q = '{8'h77};
    spi_write(7'h50, 1, -1);
    check_host(7'h50);
    spi_read_check(7'h50, 1);

    // ID register
    spi_read_check(7'h0F, 1);
    tx_q = '{8'hAA};
    spi_write(7'h0F, 1, -1);
    check_host(7'h0F);
    spi_read_check(7'h0E, 3);

    // host write colliding with an SPI commit to the same address
    tx_q = '{8'h02};
    fork
      spi_frame(8'h30, 1, -1);
      begin
        @(negedge clk);
        host_addr = 7'h30; host_wdata = 8'h01; host_we = 1'b1;
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!wr_strobe && cnt < 3000);
        chk("coll_strobe", wr_strobe, 1);
        host_we = 1'b0;
      end
    join
    model_spi_write(7'h30, 1);
    check_strobes();
    check_host(7'h30);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      a  = 7'($urandom_range(0, 127));
      n  = $urandom_range(1, 4);
      if (op == 0) begin
        host_write(a, 8'($urandom));
        check_host(a);
      end else if (op == 1) begin
        tx_q.delete();
        for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
        cut = ($urandom_range(0, 5) == 0) ? (n - 1) * 8 + $urandom_range(1, 7) : -1;
        spi_write(a, n, cut);
      end else begin
        spi_read_check(a, n);
      end
    end

    for (int i = 0; i < 128; i++) check_host(7'(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
